// File: rtl/ras_pkg.sv
// Shared definitions for the return-address stack: depth limit, operation decode
// and valid-vector helpers used by the occupancy invariant check.
package ras_pkg;

  localparam int unsigned RAS_MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    RAS_NOP,
    RAS_PUSH,
    RAS_POP,
    RAS_REPLACE
  } ras_op_e;

  function automatic ras_op_e decode_op(input logic push, input logic pop);
    unique case ({push, pop})
      2'b10:   return RAS_PUSH;
      2'b01:   return RAS_POP;
      2'b11:   return RAS_REPLACE;
      default: return RAS_NOP;
    endcase
  endfunction

  function automatic int unsigned pop_count(input logic [RAS_MAX_DEPTH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < RAS_MAX_DEPTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // A contiguous-from-bit-0 vector has the form 2^k-1.
  function automatic logic is_contiguous(input logic [RAS_MAX_DEPTH-1:0] v);
    return (v & (v + 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/ret_addr_stack_if.sv
// Call/return hint bus between pre-decode (master) and the RAS (slave).
// snapshot_i/restore_i exist only when RAS_CHECKPOINT_EN is defined.
interface ret_addr_stack_if #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned VLEN  = 64
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             flush_i;
   logic             push_i;
   logic             pop_i;
   logic [VLEN-1:0]  data_i;
`ifdef RAS_CHECKPOINT_EN
   logic             snapshot_i;
   logic             restore_i;
`endif
   logic             top_valid_o;
   logic [VLEN-1:0]  top_addr_o;
   logic [CNT_W-1:0] count_o;
   logic             overflow_o;

   modport master (
      output flush_i, push_i, pop_i, data_i,
`ifdef RAS_CHECKPOINT_EN
             snapshot_i, restore_i,
`endif
      input  top_valid_o, top_addr_o, count_o, overflow_o
   );

   modport slave (
      input  flush_i, push_i, pop_i, data_i,
`ifdef RAS_CHECKPOINT_EN
             snapshot_i, restore_i,
`endif
      output top_valid_o, top_addr_o, count_o, overflow_o
   );
endinterface

// File: rtl/ret_addr_stack.sv
// Shift-register return-address stack; index 0 is the top of stack.
// Define RAS_CHECKPOINT_EN to add a shadow copy with snapshot/restore.
module ret_addr_stack
   import ras_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned VLEN  = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   ret_addr_stack_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] addr;
   } ras_entry_t;

   if (DEPTH < 1 || DEPTH > RAS_MAX_DEPTH) begin : g_bad_depth
      $error("ret_addr_stack: DEPTH out of range 1..16");
   end

   ras_entry_t       stack_q [DEPTH];
   ras_entry_t       stack_d [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   ras_op_e          op;

`ifdef RAS_CHECKPOINT_EN
   ras_entry_t       shadow_q [DEPTH];
   ras_entry_t       shadow_d [DEPTH];
   logic [CNT_W-1:0] shadow_cnt_q, shadow_cnt_d;
`endif

   assign op = decode_op(bus.push_i, bus.pop_i);

   // NOTE: every output of this block gets a default before any branch, so no
   // path leaves a variable unassigned and no latch is inferred.
   always_comb begin
      stack_d = stack_q;
      cnt_d   = cnt_q;
      ovf_d   = 1'b0;
`ifdef RAS_CHECKPOINT_EN
      shadow_d     = shadow_q;
      shadow_cnt_d = shadow_cnt_q;
      if (bus.snapshot_i && !bus.restore_i) begin
         shadow_d     = stack_q;
         shadow_cnt_d = cnt_q;
      end
`endif

      if (bus.flush_i) begin
         // Addresses are left in place; only the valid bits matter.
         for (int i = 0; i < DEPTH; i++) stack_d[i].valid = 1'b0;
         cnt_d = '0;
`ifdef RAS_CHECKPOINT_EN
         for (int i = 0; i < DEPTH; i++) shadow_d[i].valid = 1'b0;
         shadow_cnt_d = '0;
`endif
      end
`ifdef RAS_CHECKPOINT_EN
      else if (bus.restore_i) begin
         stack_d = shadow_q;
         cnt_d   = shadow_cnt_q;
      end
`endif
      else begin
         unique case (op)
            RAS_PUSH: begin
               for (int i = 1; i < DEPTH; i++) stack_d[i] = stack_q[i-1];
               stack_d[0] = '{valid: 1'b1, addr: bus.data_i};
               ovf_d      = stack_q[DEPTH-1].valid;
               if (cnt_q != CNT_W'(DEPTH)) cnt_d = cnt_q + CNT_W'(1);
            end
            RAS_POP: begin
               if (cnt_q != '0) begin
                  for (int i = 0; i < DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
                  stack_d[DEPTH-1] = '0;
                  cnt_d            = cnt_q - CNT_W'(1);
               end
            end
            RAS_REPLACE: begin
               stack_d[0] = '{valid: 1'b1, addr: bus.data_i};
               if (cnt_q == '0) cnt_d = CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   // NOTE: the entry array is small and its reset state is architecturally
   // visible (top_addr_o must read 0), so every entry is reset, not just valid.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
`ifdef RAS_CHECKPOINT_EN
         for (int i = 0; i < DEPTH; i++) shadow_q[i] <= '0;
         shadow_cnt_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge value, which is what the shift chain depends on.
         stack_q <= stack_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
`ifdef RAS_CHECKPOINT_EN
         shadow_q     <= shadow_d;
         shadow_cnt_q <= shadow_cnt_d;
`endif
      end
   end

   assign bus.top_valid_o = stack_q[0].valid;
   assign bus.top_addr_o  = stack_q[0].addr;
   assign bus.count_o     = cnt_q;
   assign bus.overflow_o  = ovf_q;

   logic [RAS_MAX_DEPTH-1:0] valid_vec;
   always_comb begin
      valid_vec = '0;
      for (int i = 0; i < DEPTH; i++) valid_vec[i] = stack_q[i].valid;
   end

   a_contiguous : assert property (@(posedge clk_i) disable iff (rst_i)
      is_contiguous(valid_vec));
   a_count_match : assert property (@(posedge clk_i) disable iff (rst_i)
      32'(cnt_q) == pop_count(valid_vec));

endmodule

// File: tb/tb_ret_addr_stack.sv
// Table-driven bench for ret_addr_stack (DEPTH=2, VLEN=64) with an expected-value
// queue; the checkpoint sequence runs when RAS_CHECKPOINT_EN is defined.
module tb_ret_addr_stack;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned VLEN  = 64;

  typedef struct {
    string       name;
    logic        rst, flush, push, pop, snap, rest;
    logic [63:0] data;
    logic        exp_v;
    logic [63:0] exp_addr;
    logic        chk_addr;
    logic [1:0]  exp_cnt;
    logic        exp_ovf;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  vec_t   vecs[$];
  vec_t   sb[$];
  int     n_pass  = 0;
  int     n_total = 0;

  ret_addr_stack_if #(.DEPTH(DEPTH), .VLEN(VLEN)) bus ();

  ret_addr_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(string name, logic r, logic f, logic pu, logic po,
                              logic sn, logic re, logic [63:0] d, logic ev,
                              logic [63:0] ea, logic ca, logic [1:0] ec, logic eo);
    vec_t v;
    v.name = name; v.rst = r; v.flush = f; v.push = pu; v.pop = po;
    v.snap = sn; v.rest = re; v.data = d; v.exp_v = ev; v.exp_addr = ea;
    v.chk_addr = ca; v.exp_cnt = ec; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one vector at the falling edge, queue its expectation, compare after the edge.
  task automatic step(input vec_t v);
    vec_t e;
    rst         = v.rst;
    bus.flush_i = v.flush;
    bus.push_i  = v.push;
    bus.pop_i   = v.pop;
    bus.data_i  = v.data;
`ifdef RAS_CHECKPOINT_EN
    bus.snapshot_i = v.snap;
    bus.restore_i  = v.rest;
`endif
    sb.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check({e.name, ".valid"}, 64'(bus.top_valid_o), 64'(e.exp_v));
    if (e.chk_addr) check({e.name, ".addr"}, bus.top_addr_o, e.exp_addr);
    check({e.name, ".count"}, 64'(bus.count_o), 64'(e.exp_cnt));
    check({e.name, ".ovf"}, 64'(bus.overflow_o), 64'(e.exp_ovf));
  endtask

  initial begin
    logic [63:0] a0, a1, a2;
    rst = 1'b1;
    bus.flush_i = 1'b0; bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.data_i = '0;
`ifdef RAS_CHECKPOINT_EN
    bus.snapshot_i = 1'b0; bus.restore_i = 1'b0;
`endif
    @(negedge clk);

    //                 name          rst f pu po sn re data           v  addr           ca cnt ovf
    vecs.push_back(mk("reset",        1, 0, 0, 0, 0, 0, 64'h0,         0, 64'h0,         1, 0, 0));
    vecs.push_back(mk("push_first",   0, 0, 1, 0, 0, 0, 64'h8000_0010, 1, 64'h8000_0010, 1, 1, 0));
    vecs.push_back(mk("pop_first",    0, 0, 0, 1, 0, 0, 64'h0,         0, 64'h0,         1, 0, 0));
    vecs.push_back(mk("push_100",     0, 0, 1, 0, 0, 0, 64'h100,       1, 64'h100,       1, 1, 0));
    vecs.push_back(mk("push_200",     0, 0, 1, 0, 0, 0, 64'h200,       1, 64'h200,       1, 2, 0));
    vecs.push_back(mk("push_300_ovf", 0, 0, 1, 0, 0, 0, 64'h300,       1, 64'h300,       1, 2, 1));
    vecs.push_back(mk("idle_full",    0, 0, 0, 0, 0, 0, 64'h0,         1, 64'h300,       1, 2, 0));
    vecs.push_back(mk("pop_to_200",   0, 0, 0, 1, 0, 0, 64'h0,         1, 64'h200,       1, 1, 0));
    vecs.push_back(mk("pop_to_empty", 0, 0, 0, 1, 0, 0, 64'h0,         0, 64'h0,         1, 0, 0));
    vecs.push_back(mk("pop_on_empty", 0, 0, 0, 1, 0, 0, 64'h0,         0, 64'h0,         1, 0, 0));
    vecs.push_back(mk("repl_empty",   0, 0, 1, 1, 0, 0, 64'h440,       1, 64'h440,       1, 1, 0));
    vecs.push_back(mk("pop_440",      0, 0, 0, 1, 0, 0, 64'h0,         0, 64'h0,         1, 0, 0));
    vecs.push_back(mk("push_20",      0, 0, 1, 0, 0, 0, 64'h20,        1, 64'h20,        1, 1, 0));
    vecs.push_back(mk("push_10",      0, 0, 1, 0, 0, 0, 64'h10,        1, 64'h10,        1, 2, 0));
    vecs.push_back(mk("repl_full",    0, 0, 1, 1, 0, 0, 64'h30,        1, 64'h30,        1, 2, 0));
    vecs.push_back(mk("pop_30",       0, 0, 0, 1, 0, 0, 64'h0,         1, 64'h20,        1, 1, 0));
    vecs.push_back(mk("push_b0",      0, 0, 1, 0, 0, 0, 64'hB0,        1, 64'hB0,        1, 2, 0));
    vecs.push_back(mk("push_a0_ovf",  0, 0, 1, 0, 0, 0, 64'hA0,        1, 64'hA0,        1, 2, 1));
    vecs.push_back(mk("flush_push",   0, 1, 1, 0, 0, 0, 64'hC0,        0, 64'h0,         0, 0, 0));
    vecs.push_back(mk("pop_flushed",  0, 0, 0, 1, 0, 0, 64'h0,         0, 64'h0,         0, 0, 0));
    vecs.push_back(mk("push_55",      0, 0, 1, 0, 0, 0, 64'h55,        1, 64'h55,        1, 1, 0));
    vecs.push_back(mk("rst_push",     1, 0, 1, 0, 0, 0, 64'h66,        0, 64'h0,         1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // Random addresses through push, replace and pop, to catch stuck address bits.
    a0 = {$urandom, $urandom};
    a1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    step(mk("rnd_push_a0", 0, 0, 1, 0, 0, 0, a0,    1, a0,    1, 1, 0));
    step(mk("rnd_push_a1", 0, 0, 1, 0, 0, 0, a1,    1, a1,    1, 2, 0));
    step(mk("rnd_pop_a1",  0, 0, 0, 1, 0, 0, 64'h0, 1, a0,    1, 1, 0));
    step(mk("rnd_repl_a2", 0, 0, 1, 1, 0, 0, a2,    1, a2,    1, 1, 0));
    step(mk("rnd_pop_a2",  0, 0, 0, 1, 0, 0, 64'h0, 0, 64'h0, 1, 0, 0));

`ifdef RAS_CHECKPOINT_EN
    step(mk("cp_push_1",    0, 0, 1, 0, 0, 0, 64'h1,  1, 64'h1, 1, 1, 0));
    step(mk("cp_snap_push", 0, 0, 1, 0, 1, 0, 64'h2,  1, 64'h2, 1, 2, 0));
    step(mk("cp_pop_2",     0, 0, 0, 1, 0, 0, 64'h0,  1, 64'h1, 1, 1, 0));
    step(mk("cp_pop_1",     0, 0, 0, 1, 0, 0, 64'h0,  0, 64'h0, 1, 0, 0));
    step(mk("cp_restore",   0, 0, 1, 0, 0, 1, 64'h9,  1, 64'h1, 1, 1, 0));
    step(mk("cp_snap_rest", 0, 0, 0, 0, 1, 1, 64'h0,  1, 64'h1, 1, 1, 0));
    step(mk("cp_flush",     0, 1, 0, 0, 0, 0, 64'h0,  0, 64'h0, 0, 0, 0));
    step(mk("cp_rest_inv",  0, 0, 0, 0, 0, 1, 64'h0,  0, 64'h0, 0, 0, 0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
Return-address stack (RAS) for the frontend branch predictor of the 64-bit core. It takes call/return hints from instruction pre-decode and gives the predicted return target to the next-PC select logic one cycle later. Stack depth comes from the core configuration's RASDepth field (default 2). The block is shift-register based, with overflow, underflow, flush and optional checkpoint recovery.

Parameters:
DEPTH, 2, number of stack entries (from cfg RASDepth); legal range 1..16
VLEN, 64, return-address width in bits (from cfg VLEN)
CNT_W, $clog2(DEPTH+1), width of the occupancy counter (derived, not overridable)

Ports:
clk_i  input  1  core clock
rst_i  input  1  synchronous reset, active-high
flush_i  input  1  invalidate all entries (frontend flush / fence.i)
push_i  input  1  call detected; push data_i
pop_i  input  1  return detected; pop top entry
data_i  input  VLEN  return address to push (PC of call + 2 or + 4)
top_valid_o  output  1  top entry holds a valid prediction
top_addr_o  output  VLEN  predicted return address (top entry)
count_o  output  CNT_W  number of valid entries, 0..DEPTH
overflow_o  output  1  one-cycle pulse: a push discarded the bottom valid entry
snapshot_i  input  1  (RAS_CHECKPOINT_EN only) capture current stack
restore_i  input  1  (RAS_CHECKPOINT_EN only) reload captured stack

Behaviour:
- Storage: stack_q[0..DEPTH-1] of entries {valid, addr}. Index 0 is the top.
- Outputs: top_valid_o = stack_q[0].valid; top_addr_o = stack_q[0].addr. Both are purely combinational from registers, so an update is visible the cycle after the operation.
- Reset (rst_i=1 at a clock edge): every valid bit and addr clears to 0; count_o=0; overflow_o=0. Reset wins over every other input, including mid-operation.
- Update priority, highest first: rst_i > flush_i > restore_i > push/pop.
- flush_i: all valid bits clear; addr contents are don't-care (keep them, to save toggles); count_o becomes 0.
- Push only: entries shift down (stack_q[i+1] <= stack_q[i]); stack_q[0] <= {1, data_i}.
  - The old bottom entry is dropped.
  - overflow_o=1 for one cycle if that dropped entry was valid.
  - count_o saturates at DEPTH.
- Pop only: entries shift up (stack_q[i] <= stack_q[i+1]); stack_q[DEPTH-1] <= {0, 0}; count_o decrements.
- Pop on empty (count_o=0): no state change, count_o stays 0, no error flag.
- Push and pop in the same cycle (e.g. jalr that is both a return and a call): replace the top, stack_q[0] <= {1, data_i}. No shift, and count_o is unchanged. If the stack was empty, the top becomes valid and count_o becomes 1.
- count_o always equals the number of set valid bits. Valid entries stay contiguous from index 0 (invariant; assert it in simulation).
- DEPTH=1: shifting degenerates to a single register; overflow_o pulses on every push to a valid entry.

Optional Feature:
- Macro: RAS_CHECKPOINT_EN.
- When defined:
  - A shadow copy of the stack and count is kept.
  - snapshot_i copies the pre-update state, i.e. the registers before any same-cycle push/pop.
  - restore_i reloads stack_q and count from the shadow in one cycle and ignores push/pop in that cycle.
  - snapshot_i together with restore_i: restore wins and the shadow is left unchanged.
  - flush_i and rst_i also invalidate the shadow.
- When undefined: snapshot_i and restore_i ports are absent, and no shadow registers exist.

Decomposition:
- Shared package ras_pkg:
  - ras_entry_t, a parameterized struct {logic valid; logic [VLEN-1:0] addr}, built via the cfg-typed parameter.
  - localparam RAS_MAX_DEPTH = 16.
- No sub-module. The shift array and the shadow copy are both small; a single module of about 150–250 lines is natural.

Test Plan:
- Reset → push 0x8000_0010 → next cycle top_valid_o=1, top_addr_o=0x8000_0010, count_o=1.
- Push 0x100, then 0x200, then 0x300 (DEPTH=2):
  - overflow_o pulses on the third push.
  - Stack holds {0x300, 0x200}; count_o=2.
  - Two pops return 0x300 then 0x200; a third pop leaves count_o=0 and top_valid_o=0.
- Empty stack with push+pop of 0x440 in the same cycle → top_addr_o=0x440, count_o=1. With stack {0x10, 0x20}, push+pop of 0x30 → {0x30, 0x20}, count_o=2.
- Stack {0xA0, 0xB0}; assert flush_i and push_i of 0xC0 in the same cycle → count_o=0, top_valid_o=0, no overflow_o.
- Assert rst_i in the same cycle as push_i → all outputs are 0 next cycle.
- With RAS_CHECKPOINT_EN:
  - Stack {0x1}; assert snapshot_i and push_i of 0x2 together → stack becomes {0x2, 0x1}.
  - Then pop twice and assert restore_i → stack returns to {0x1}, count_o=1.
